// File: rtl/sm_trace_buf_pkg.sv
// Shared types for the schoolMIPS instruction trace buffer.
// Holds the capture FSM encoding and the packed entry width helper.
package sm_trace_buf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } traceState_t;

   // Entry packing order is {cycle, pc, instr}, with the cycle stamp in the MSBs.
   function automatic int entryWidth(input int cycleW, input int pcW, input int instrW);
      return cycleW + pcW + instrW;
   endfunction

endpackage

// File: rtl/sm_trace_ram.sv
// Simple dual-port trace RAM: one write port and one registered read port.
// The read returns the old word when it hits the address being written.
module sm_trace_ram #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 80
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: no reset on the array or read register so this maps onto block RAM;
   // the owner masks rdData until a valid read has been issued.
   always_ff @(posedge clk) begin
      if (we) mem[wrAddr] <= wrData;
      rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/sm_trace_buf.sv
// Instruction trace buffer: arms on request, triggers on a PC match,
// captures a post-trigger window or stops on timeout, then freezes for readout.
module sm_trace_buf
   import sm_trace_buf_pkg::*;
#(
   parameter int DEPTH_LOG2 = 6,
   parameter int PC_W       = 32,
   parameter int INSTR_W    = 32,
   parameter int CYCLE_W    = 16,
   parameter int TIMEOUT    = 120
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic                  trig_en,
   input  logic [PC_W-1:0]       trig_pc,
   input  logic [DEPTH_LOG2:0]   post_cnt,
   input  logic                  trace_valid,
   input  logic [PC_W-1:0]       trace_pc,
   input  logic [INSTR_W-1:0]    trace_instr,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [PC_W-1:0]       rd_pc,
   output logic [INSTR_W-1:0]    rd_instr,
   output logic [CYCLE_W-1:0]    rd_cycle,
   output logic [1:0]            state,
   output logic [DEPTH_LOG2:0]   count,
   output logic [DEPTH_LOG2-1:0] trig_idx,
   output logic                  triggered,
   output logic                  timeout
);

   localparam int ENTRY_W = entryWidth(CYCLE_W, PC_W, INSTR_W);
   localparam int DEPTH   = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [CYCLE_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CYCLE_W'(TIMEOUT - 1);

   traceState_t           stateQ, stateNext;
   logic [DEPTH_LOG2-1:0] wrPtr;
   logic [DEPTH_LOG2-1:0] remaining;
   logic [DEPTH_LOG2-1:0] postEff;
   logic [CYCLE_W-1:0]    cycleCnt;
   logic                  capturing;
   logic                  doWrite;
   logic                  doTrig;
   logic                  toHit;
   logic                  rdHit;
   logic [DEPTH_LOG2-1:0] rdAddr;
   logic [ENTRY_W-1:0]    ramRdData;
   logic [CYCLE_W-1:0]    ramCycle;
   logic [PC_W-1:0]       ramPc;
   logic [INSTR_W-1:0]    ramInstr;

   assign capturing = (stateQ == ARMED) || (stateQ == POST);
   assign toHit     = (TIMEOUT != 0) && capturing && (cycleCnt == TO_LAST);
   // Requests above DEPTH-1 would otherwise wrap the 6-bit remaining counter.
   assign postEff   = post_cnt[DEPTH_LOG2] ? '1 : post_cnt[DEPTH_LOG2-1:0];

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      stateNext = stateQ;
      doWrite   = 1'b0;
      doTrig    = 1'b0;
      if (arm) begin
         stateNext = ARMED;
      end else if (capturing) begin
         doWrite = trace_valid;
         if (stateQ == ARMED) begin
            doTrig = trig_en && trace_valid && (trace_pc == trig_pc);
            if (doTrig) stateNext = (postEff == '0) ? DONE : POST;
         end else if (trace_valid && remaining == DEPTH_LOG2'(1)) begin
            stateNext = DONE;
         end
         if (toHit) stateNext = DONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= IDLE;
         wrPtr     <= '0;
         count     <= '0;
         cycleCnt  <= '0;
         remaining <= '0;
         trig_idx  <= '0;
         triggered <= 1'b0;
         timeout   <= 1'b0;
         rdHit     <= 1'b0;
      end else begin
         stateQ <= stateNext;
         rdHit  <= ({1'b0, rd_idx} < count);
         if (arm) begin
            wrPtr     <= '0;
            count     <= '0;
            cycleCnt  <= '0;
            trig_idx  <= '0;
            triggered <= 1'b0;
            timeout   <= 1'b0;
         end else if (capturing) begin
            if (cycleCnt != '1) cycleCnt <= cycleCnt + 1'b1;
            if (doWrite) begin
               wrPtr <= wrPtr + 1'b1;
               if (count != FULL) count <= count + 1'b1;
            end
            if (doTrig) begin
               // A full buffer means the trigger entry lands as the newest one.
               triggered <= 1'b1;
               trig_idx  <= (count == FULL) ? '1 : count[DEPTH_LOG2-1:0];
               remaining <= postEff;
            end else if (stateQ == POST && doWrite) begin
               remaining <= remaining - 1'b1;
               if (count == FULL && trig_idx != '0) trig_idx <= trig_idx - 1'b1;
            end
            if (toHit) timeout <= 1'b1;
         end
      end
   end

   assign rdAddr = wrPtr - count[DEPTH_LOG2-1:0] + rd_idx;

   sm_trace_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (ENTRY_W)
   ) traceRam (
      .clk    (clk),
      .we     (doWrite),
      .wrAddr (wrPtr),
      .wrData ({cycleCnt, trace_pc, trace_instr}),
      .rdAddr (rdAddr),
      .rdData (ramRdData)
   );

   assign {ramCycle, ramPc, ramInstr} = ramRdData;
   assign rd_cycle = rdHit ? ramCycle : '0;
   assign rd_pc    = rdHit ? ramPc    : '0;
   assign rd_instr = rdHit ? ramInstr : '0;
   assign state    = stateQ;

endmodule
